// File: rtl/vcounter.sv
// Vertical timing stage: advances one scanline per last_h pulse and derives the
// character-row addressing, blanking, sync, frame strobe and cursor-blink phase.
module vcounter #(
  parameter int ROWS          = 24,
  parameter int LINES_PER_ROW = 8,
  parameter int V_TOTAL       = 262,
  parameter int VSYNC_START   = 224,
  parameter int VSYNC_LEN     = 4,
  parameter int BLINK_FRAMES  = 15
) (
  input  logic       clk,
  input  logic       mr,
  input  logic       last_h,
  output logic [8:0] v_count,
  output logic [2:0] line,
  output logic [4:0] row,
  output logic       vbl_n,
  output logic       v_sync_n,
  output logic       frame_end,
  output logic       blink
);

  localparam logic [8:0] ACTIVE      = 9'(ROWS * LINES_PER_ROW);
  localparam logic [8:0] ACTIVE_LAST = 9'(ROWS * LINES_PER_ROW - 1);
  localparam logic [8:0] V_LAST      = 9'(V_TOTAL - 1);
  localparam logic [2:0] LINE_LAST   = 3'(LINES_PER_ROW - 1);
  // Sync bounds carry a tenth bit so a window ending at scanline 512 still compares correctly.
  localparam logic [9:0] VS_BEG      = 10'(VSYNC_START);
  localparam logic [9:0] VS_END      = 10'(VSYNC_START + VSYNC_LEN);
  localparam int         FC_W        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  logic [8:0]      v_count_q, v_count_d;
  logic [2:0]      line_q, line_d;
  logic [4:0]      row_q, row_d;
  logic            vbl_n_q, vbl_n_d;
  logic            v_sync_n_q, v_sync_n_d;
  logic            frame_end_q, frame_end_d;
  logic            blink_q, blink_d;
  logic [FC_W-1:0] fc_q, fc_d;

  always_comb begin
    v_count_d   = v_count_q;
    line_d      = line_q;
    row_d       = row_q;
    fc_d        = fc_q;
    blink_d     = blink_q;
    frame_end_d = 1'b0;
    if (last_h) begin
      if (v_count_q == V_LAST) begin
        v_count_d   = 9'd0;
        line_d      = 3'd0;
        row_d       = 5'd0;
        frame_end_d = 1'b1;
        if (fc_q == FC_LAST) begin
          fc_d    = '0;
          blink_d = ~blink_q;
        end else begin
          fc_d = fc_q + FC_W'(1);
        end
      end else begin
        v_count_d = v_count_q + 9'd1;
        // From the last active scanline onward, line/row park at zero for blanking.
        if (v_count_q >= ACTIVE_LAST) begin
          line_d = 3'd0;
          row_d  = 5'd0;
        end else if (line_q == LINE_LAST) begin
          line_d = 3'd0;
          row_d  = row_q + 5'd1;
        end else begin
          line_d = line_q + 3'd1;
        end
      end
    end
    vbl_n_d    = (v_count_d < ACTIVE);
    v_sync_n_d = !(({1'b0, v_count_d} >= VS_BEG) && ({1'b0, v_count_d} < VS_END));
  end

  always_ff @(posedge clk or posedge mr) begin
    if (mr) begin
      v_count_q   <= 9'd0;
      line_q      <= 3'd0;
      row_q       <= 5'd0;
      vbl_n_q     <= 1'b1;
      v_sync_n_q  <= 1'b1;
      frame_end_q <= 1'b0;
      blink_q     <= 1'b0;
      fc_q        <= '0;
    end else begin
      v_count_q   <= v_count_d;
      line_q      <= line_d;
      row_q       <= row_d;
      vbl_n_q     <= vbl_n_d;
      v_sync_n_q  <= v_sync_n_d;
      frame_end_q <= frame_end_d;
      blink_q     <= blink_d;
      fc_q        <= fc_d;
    end
  end

  assign v_count   = v_count_q;
  assign line      = line_q;
  assign row       = row_q;
  assign vbl_n     = vbl_n_q;
  assign v_sync_n  = v_sync_n_q;
  assign frame_end = frame_end_q;
  assign blink     = blink_q;

endmodule

// File: tb/tb_vcounter.sv
// Scoreboard bench for vcounter: a scanline/frame model predicts every output.
module tb_vcounter;
  logic       clk = 1'b0;
  logic       mr;
  logic       last_h;
  logic [8:0] v_count;
  logic [2:0] line;
  logic [4:0] row;
  logic       vbl_n, v_sync_n, frame_end, blink;

  always #5 clk = ~clk;

  vcounter dut (
    .clk(clk), .mr(mr), .last_h(last_h), .v_count(v_count), .line(line),
    .row(row), .vbl_n(vbl_n), .v_sync_n(v_sync_n), .frame_end(frame_end), .blink(blink)
  );

  typedef struct packed {
    logic [8:0] v;
    logic [2:0] ln;
    logic [4:0] rw;
    logic       vbl_n;
    logic       vs_n;
    logic       fe;
    logic       blink;
  } obs_t;

  obs_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_v      = 0;
  int   m_frames = 0;
  logic m_fe     = 1'b0;

  function automatic obs_t expect_now();
    obs_t e;
    e.v     = 9'(m_v);
    e.ln    = (m_v < 192) ? 3'(m_v % 8) : 3'd0;
    e.rw    = (m_v < 192) ? 5'(m_v / 8) : 5'd0;
    e.vbl_n = (m_v < 192);
    e.vs_n  = !(m_v >= 224 && m_v < 228);
    e.fe    = m_fe;
    e.blink = ((m_frames / 15) % 2) == 1;
    return e;
  endfunction

  function automatic obs_t observe();
    return {v_count, line, row, vbl_n, v_sync_n, frame_end, blink};
  endfunction

  task automatic model_reset();
    m_v = 0; m_frames = 0; m_fe = 1'b0;
  endtask

  // Drive last_h for the coming edge and queue what the outputs must be after it.
  task automatic drive(input logic lh);
    last_h = lh;
    if (lh) begin
      m_fe = (m_v == 261);
      if (m_v == 261) begin
        m_v = 0;
        m_frames++;
      end else begin
        m_v++;
      end
    end else begin
      m_fe = 1'b0;
    end
    q.push_back(expect_now());
  endtask

  task automatic test_reset();
    obs_t e, o;
    mr = 1'b1; last_h = 1'b0;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      last_h = (i % 2 == 0);
      q.push_back(expect_now());
      @(negedge clk);
      e = q.pop_front(); o = observe(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d: got %h expected %h", i, o, e);
      end
    end
    mr = 1'b0;
    drive(1'b1);
    @(negedge clk);
    e = q.pop_front(); o = observe(); n_tests++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL reset_first_pulse: got %h expected %h", o, e);
    end
  endtask

  // Pulses up to scanline 191 with idle cycles mixed in to check holding.
  task automatic test_row_boundary();
    obs_t e, o;
    int c;
    c = 0;
    while (m_v < 191 && c < 1000) begin
      drive((c % 3) != 2);
      c++;
      @(negedge clk);
      e = q.pop_front(); o = observe(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL row_boundary v=%0d: got %h expected %h", m_v, o, e);
      end
    end
    n_tests++;
    if (line !== 3'd7 || row !== 5'd23) begin
      n_fail++;
      $display("FAIL row_last: line/row got %0d/%0d expected 7/23", line, row);
    end
  endtask

  task automatic test_blank_entry();
    obs_t e, o;
    for (int i = 0; i < 32; i++) begin
      drive(1'b1);
      @(negedge clk);
      e = q.pop_front(); o = observe(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL blank_entry v=%0d: got %h expected %h", m_v, o, e);
      end
    end
  endtask

  task automatic test_vsync();
    obs_t e, o;
    for (int i = 0; i < 38; i++) begin
      drive(1'b1);
      @(negedge clk);
      e = q.pop_front(); o = observe(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL vsync v=%0d: got %h expected %h", m_v, o, e);
      end
    end
  endtask

  // Wrap 261 -> 0 followed by idle cycles: frame_end must be a single clock.
  task automatic test_wrap();
    obs_t e, o;
    for (int i = 0; i < 4; i++) begin
      drive(i == 0);
      @(negedge clk);
      e = q.pop_front(); o = observe(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL wrap cyc=%0d: got %h expected %h", i, o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, o;
    for (int i = 0; i < 270; i++) begin
      drive(1'b1);
      @(negedge clk);
      e = q.pop_front(); o = observe(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL back_to_back v=%0d: got %h expected %h", m_v, o, e);
      end
    end
  endtask

  task automatic test_blink();
    obs_t e, o;
    int c;
    c = 0;
    while (!(m_frames == 30 && m_v == 2) && c < 9000) begin
      drive(1'b1);
      c++;
      @(negedge clk);
      e = q.pop_front(); o = observe(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL blink frame=%0d v=%0d: got %h expected %h", m_frames, m_v, o, e);
      end
      if (m_v == 1 && (m_frames == 15 || m_frames == 30)) begin
        n_tests++;
        if (blink !== (m_frames == 15)) begin
          n_fail++;
          $display("FAIL blink_phase frame=%0d: got %b expected %b", m_frames, blink, m_frames == 15);
        end
      end
    end
  endtask

  task automatic test_midop_reset();
    obs_t e, o;
    int c;
    c = 0;
    while (m_v != 225 && c < 600) begin
      drive(1'b1);
      c++;
      @(negedge clk);
      e = q.pop_front(); o = observe(); n_tests++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL midop_run v=%0d: got %h expected %h", m_v, o, e);
      end
    end
    last_h = 1'b1;
    mr = 1'b1;
    model_reset();
    q.push_back(expect_now());
    #1;
    e = q.pop_front(); o = observe(); n_tests++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL midop_async_reset: got %h expected %h", o, e);
    end
    q.push_back(expect_now());
    @(negedge clk);
    e = q.pop_front(); o = observe(); n_tests++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL midop_reset_held: got %h expected %h", o, e);
    end
    mr = 1'b0;
    drive(1'b1);
    @(negedge clk);
    e = q.pop_front(); o = observe(); n_tests++;
    if (o !== e) begin
      n_fail++;
      $display("FAIL midop_resume: got %h expected %h", o, e);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mr = 1'b1;
    last_h = 1'b0;
    test_reset();
    test_row_boundary();
    test_blank_entry();
    test_vsync();
    test_wrap();
    test_back_to_back();
    test_blink();
    test_midop_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
